// File: rtl/sram_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : sram_bridge
//  Description : Sequences a single-word CPU memory request onto one of two
//                asynchronous SRAM banks (base / ext), generating CE/OE/WE
//                setup, strobe and hold timing and a one-cycle ack.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_bridge #(
  parameter int RD_CYCLES = 2,
  parameter int WR_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [20:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        ack_o,
  output logic        busy_o,
  output logic [19:0] base_addr_o,
  inout  wire  [31:0] base_data_io,
  output logic        base_ce_n_o,
  output logic        base_oe_n_o,
  output logic        base_we_n_o,
  output logic [19:0] ext_addr_o,
  inout  wire  [31:0] ext_data_io,
  output logic        ext_ce_n_o,
  output logic        ext_oe_n_o,
  output logic        ext_we_n_o
);

  // Strobe counter sized for the longer of the two strobe phases.
  localparam int MAX_CYCLES = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_CYCLES - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD     = 3'd1,
    S_WSETUP = 3'd2,
    S_WPULSE = 3'd3,
    S_WHOLD  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sel_q, sel_d;        // 0 = base bank, 1 = ext bank
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              ack_q, ack_d;
  logic              busy_q, busy_d;
  // Per-bank strobes, index 0 = base, 1 = ext; each is a direct flop output.
  logic [1:0]        ce_n_q, ce_n_d;
  logic [1:0]        oe_n_q, oe_n_d;
  logic [1:0]        we_n_q, we_n_d;
  logic [1:0]        drv_q, drv_d;
  logic [1:0][19:0]  baddr_q, baddr_d;

  // Next-state and next-output computation for the transaction sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ack_d   = 1'b0;
    busy_d  = busy_q;
    ce_n_d  = ce_n_q;
    oe_n_d  = oe_n_q;
    we_n_d  = we_n_q;
    drv_d   = drv_q;
    baddr_d = baddr_q;

    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          sel_d                  = addr_i[20];
          wdata_d                = wdata_i;
          busy_d                 = 1'b1;
          // Address and CE are launched together; the address stays put
          // until CE has been released again.
          baddr_d[addr_i[20]]    = addr_i[19:0];
          ce_n_d[addr_i[20]]     = 1'b0;
          if (we_i) begin
            // Data goes on the bus one cycle ahead of the WE pulse.
            drv_d[addr_i[20]]    = 1'b1;
            state_d              = S_WSETUP;
          end else begin
            oe_n_d[addr_i[20]]   = 1'b0;
            cnt_d                = RD_LOAD;
            state_d              = S_RD;
          end
        end
      end

      S_RD: begin
        if (cnt_q == '0) begin
          // Sample the SRAM output on the final edge of the OE window.
          rdata_d = sel_q ? ext_data_io : base_data_io;
          ce_n_d  = 2'b11;
          oe_n_d  = 2'b11;
          ack_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_WSETUP: begin
        we_n_d[sel_q] = 1'b0;
        cnt_d         = WR_LOAD;
        state_d       = S_WPULSE;
      end

      S_WPULSE: begin
        if (cnt_q == '0) begin
          // WE rises while CE, address and data are still held.
          we_n_d  = 2'b11;
          state_d = S_WHOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_WHOLD: begin
        ce_n_d  = 2'b11;
        drv_d   = 2'b00;
        ack_d   = 1'b1;
        state_d = S_DONE;
      end

      S_DONE: begin
        // CE is already high here, so the address can safely return to 0.
        busy_d  = 1'b0;
        baddr_d = '0;
        state_d = S_IDLE;
      end

      default: begin
        ce_n_d  = 2'b11;
        oe_n_d  = 2'b11;
        we_n_d  = 2'b11;
        drv_d   = 2'b00;
        busy_d  = 1'b0;
        baddr_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any transaction in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sel_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      ce_n_q  <= 2'b11;
      oe_n_q  <= 2'b11;
      we_n_q  <= 2'b11;
      drv_q   <= 2'b00;
      baddr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      drv_q   <= drv_d;
      baddr_q <= baddr_d;
    end
  end

  assign rdata_o     = rdata_q;
  assign ack_o       = ack_q;
  assign busy_o      = busy_q;

  assign base_addr_o = baddr_q[0];
  assign base_ce_n_o = ce_n_q[0];
  assign base_oe_n_o = oe_n_q[0];
  assign base_we_n_o = we_n_q[0];
  assign base_data_io = drv_q[0] ? wdata_q : {32{1'bz}};

  assign ext_addr_o  = baddr_q[1];
  assign ext_ce_n_o  = ce_n_q[1];
  assign ext_oe_n_o  = oe_n_q[1];
  assign ext_we_n_o  = we_n_q[1];
  assign ext_data_io = drv_q[1] ? wdata_q : {32{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_sram_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_bridge
//  Description : Self-checking bench for sram_bridge with behavioural SRAMs
//                and a transaction-level timing model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_bridge;

  localparam int RD_CYCLES = 2;
  localparam int WR_CYCLES = 2;
  localparam int RD_LAT    = RD_CYCLES + 1;
  localparam int WR_LAT    = WR_CYCLES + 3;

  logic        clk = 1'b0;
  logic        rst_i, req_i, we_i;
  logic [20:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        ack_o, busy_o;
  logic [19:0] base_addr_o, ext_addr_o;
  wire  [31:0] base_data_io, ext_data_io;
  logic        base_ce_n_o, base_oe_n_o, base_we_n_o;
  logic        ext_ce_n_o, ext_oe_n_o, ext_we_n_o;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  sram_bridge #(.RD_CYCLES(RD_CYCLES), .WR_CYCLES(WR_CYCLES)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .we_i(we_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o),
    .ack_o(ack_o), .busy_o(busy_o),
    .base_addr_o(base_addr_o), .base_data_io(base_data_io),
    .base_ce_n_o(base_ce_n_o), .base_oe_n_o(base_oe_n_o), .base_we_n_o(base_we_n_o),
    .ext_addr_o(ext_addr_o), .ext_data_io(ext_data_io),
    .ext_ce_n_o(ext_ce_n_o), .ext_oe_n_o(ext_oe_n_o), .ext_we_n_o(ext_we_n_o)
  );

  // Asynchronous SRAM models: drive while CE&OE low, write on WE rising.
  logic [31:0] base_mem [0:4095];
  logic [31:0] ext_mem  [0:4095];
  assign base_data_io = (!base_ce_n_o && !base_oe_n_o) ? base_mem[base_addr_o[11:0]] : {32{1'bz}};
  assign ext_data_io  = (!ext_ce_n_o && !ext_oe_n_o) ? ext_mem[ext_addr_o[11:0]] : {32{1'bz}};
  always @(posedge base_we_n_o) if (!base_ce_n_o) base_mem[base_addr_o[11:0]] <= base_data_io;
  always @(posedge ext_we_n_o)  if (!ext_ce_n_o)  ext_mem[ext_addr_o[11:0]]  <= ext_data_io;

  function automatic logic [31:0] mem_default(input logic [20:0] a);
    return (a[20] ? 32'hE000_0000 : 32'hB000_0000) | {20'h0, a[11:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Transaction model: k = cycles since acceptance edge, ack when k == len.
  logic [31:0] exp_mem [logic [20:0]];
  bit          m_active = 1'b0;
  int          m_k = 0;
  int          m_len = 0;
  bit          m_we = 1'b0;
  logic [20:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic [31:0] m_rdata = '0;

  always @(posedge clk) begin
    if (rst_i) begin
      m_active = 1'b0;
      m_k      = 0;
      m_rdata  = '0;
    end else if (m_active) begin
      if (m_k == m_len) begin
        m_active = 1'b0;
        m_k      = 0;
      end else begin
        m_k = m_k + 1;
        if (m_k == m_len) begin
          if (m_we) exp_mem[m_addr] = m_wdata;
          else m_rdata = exp_mem.exists(m_addr) ? exp_mem[m_addr] : mem_default(m_addr);
        end
      end
    end else if (req_i) begin
      m_active = 1'b1;
      m_k      = 1;
      m_we     = we_i;
      m_addr   = addr_i;
      m_wdata  = wdata_i;
      m_len    = we_i ? WR_LAT : RD_LAT;
    end
  end

  // Per-cycle comparison of every bridge output against the model.
  always @(negedge clk) begin
    logic        in_cs;
    logic [1:0]  selb;
    if (chk_en) begin
      in_cs   = m_active && (m_k < m_len);
      selb[0] = m_active && !m_addr[20];
      selb[1] = m_active &&  m_addr[20];
      check("ack",   {31'd0, ack_o},  {31'd0, (m_active && m_k == m_len)});
      check("busy",  {31'd0, busy_o}, {31'd0, m_active});
      check("rdata", rdata_o, m_rdata);
      check("base_ce_n", {31'd0, base_ce_n_o}, {31'd0, !(selb[0] && in_cs)});
      check("base_oe_n", {31'd0, base_oe_n_o}, {31'd0, !(selb[0] && !m_we && m_k <= RD_CYCLES)});
      check("base_we_n", {31'd0, base_we_n_o}, {31'd0, !(selb[0] && m_we && m_k >= 2 && m_k <= WR_CYCLES + 1)});
      check("base_addr", {12'd0, base_addr_o}, selb[0] ? {12'd0, m_addr[19:0]} : 32'd0);
      check("ext_ce_n",  {31'd0, ext_ce_n_o},  {31'd0, !(selb[1] && in_cs)});
      check("ext_oe_n",  {31'd0, ext_oe_n_o},  {31'd0, !(selb[1] && !m_we && m_k <= RD_CYCLES)});
      check("ext_we_n",  {31'd0, ext_we_n_o},  {31'd0, !(selb[1] && m_we && m_k >= 2 && m_k <= WR_CYCLES + 1)});
      check("ext_addr",  {12'd0, ext_addr_o},  selb[1] ? {12'd0, m_addr[19:0]} : 32'd0);
      if (selb[0] && m_we && in_cs) check("base_data", base_data_io, m_wdata);
      if (selb[1] && m_we && in_cs) check("ext_data",  ext_data_io,  m_wdata);
    end
  end

  // One request, dropped in its ack cycle; returns observed timing figures.
  task automatic run_txn(input logic w, input logic [20:0] a, input logic [31:0] d,
                         output int lat, output int n_we, output int n_oe,
                         output int n_drv, output int n_other_ce, output logic [19:0] sel_addr);
    bit got;
    req_i = 1'b1; we_i = w; addr_i = a; wdata_i = d;
    lat = 0; n_we = 0; n_oe = 0; n_drv = 0; n_other_ce = 0; sel_addr = '0; got = 1'b0;
    @(posedge clk);
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (a[20]) begin
        if (!ext_we_n_o) n_we++;
        if (!ext_oe_n_o) n_oe++;
        if (w && ext_data_io == d) n_drv++;
        if (!base_ce_n_o) n_other_ce++;
        if (!ext_ce_n_o) sel_addr = ext_addr_o;
      end else begin
        if (!base_we_n_o) n_we++;
        if (!base_oe_n_o) n_oe++;
        if (w && base_data_io == d) n_drv++;
        if (!ext_ce_n_o) n_other_ce++;
        if (!base_ce_n_o) sel_addr = base_addr_o;
      end
      if (ack_o) begin
        got   = 1'b1;
        req_i = 1'b0;
      end
    end
    if (!got) begin
      req_i = 1'b0;
      check("txn_ack_timeout", 32'd0, 32'd1);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat, n_we, n_oe, n_drv, n_oce;
    logic [19:0] sa;
    int n_ack, cyc, busy_low;
    int ack_t [3];

    rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
    for (int i = 0; i < 4096; i++) begin
      base_mem[i] = 32'hB000_0000 | i;
      ext_mem[i]  = 32'hE000_0000 | i;
    end

    // Reset held for two cycles.
    @(posedge clk);
    chk_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_base_ce_n", {31'd0, base_ce_n_o}, 32'd1);
    check("rst_ext_we_n",  {31'd0, ext_we_n_o},  32'd1);
    check("rst_ack",       {31'd0, ack_o},       32'd0);
    check("rst_rdata",     rdata_o,              32'd0);
    rst_i = 1'b0;
    @(posedge clk);
    #1;

    // Write base bank.
    run_txn(1'b1, 21'h00010, 32'hDEADBEEF, lat, n_we, n_oe, n_drv, n_oce, sa);
    check("wr_base_latency", 32'(lat), 32'd5);
    check("wr_base_we_cycles", 32'(n_we), 32'd2);
    check("wr_base_drv_cycles", 32'(n_drv), 32'd4);
    check("wr_base_ext_idle", 32'(n_oce), 32'd0);

    // Read it back.
    run_txn(1'b0, 21'h00010, 32'h0, lat, n_we, n_oe, n_drv, n_oce, sa);
    check("rd_base_latency", 32'(lat), 32'd3);
    check("rd_base_oe_cycles", 32'(n_oe), 32'd2);
    check("rd_base_data", rdata_o, 32'hDEADBEEF);

    // Ext bank write and read back.
    run_txn(1'b1, 21'h100FFF, 32'h12345678, lat, n_we, n_oe, n_drv, n_oce, sa);
    check("wr_ext_latency", 32'(lat), 32'd5);
    check("wr_ext_addr", {12'd0, sa}, 32'h00FFF);
    check("wr_ext_base_idle", 32'(n_oce), 32'd0);
    run_txn(1'b0, 21'h100FFF, 32'h0, lat, n_we, n_oe, n_drv, n_oce, sa);
    check("rd_ext_latency", 32'(lat), 32'd3);
    check("rd_ext_data", rdata_o, 32'h12345678);
    check("rd_ext_base_idle", 32'(n_oce), 32'd0);

    // req_i held high across three reads.
    req_i = 1'b1; we_i = 1'b0; addr_i = 21'h00010;
    n_ack = 0; cyc = 0; busy_low = 0;
    while (n_ack < 3 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (n_ack > 0 && !busy_o) busy_low++;
      if (ack_o) begin
        ack_t[n_ack] = cyc;
        n_ack++;
        if (n_ack == 3) req_i = 1'b0;
      end
    end
    req_i = 1'b0;
    check("b2b_ack_count", 32'(n_ack), 32'd3);
    check("b2b_spacing_1", 32'(ack_t[1] - ack_t[0]), 32'd4);
    check("b2b_spacing_2", 32'(ack_t[2] - ack_t[1]), 32'd4);
    check("b2b_busy_low", 32'(busy_low), 32'd2);
    check("b2b_rdata", rdata_o, 32'hDEADBEEF);
    @(posedge clk);
    #1;

    // Reset during the WE pulse of a write.
    req_i = 1'b1; we_i = 1'b1; addr_i = 21'h00020; wdata_i = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    check("abort_in_pulse", {31'd0, base_we_n_o}, 32'd0);
    rst_i = 1'b1;
    req_i = 1'b0;
    @(negedge clk);
    check("abort_we_n", {31'd0, base_we_n_o}, 32'd1);
    check("abort_ce_n", {31'd0, base_ce_n_o}, 32'd1);
    check("abort_ack",  {31'd0, ack_o},       32'd0);
    check("abort_busy", {31'd0, busy_o},      32'd0);
    rst_i = 1'b0;
    @(posedge clk);
    #1;
    run_txn(1'b0, 21'h00010, 32'h0, lat, n_we, n_oe, n_drv, n_oce, sa);
    check("post_abort_latency", 32'(lat), 32'd3);
    check("post_abort_rdata", rdata_o, 32'hDEADBEEF);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
